mux4_rr_tx: RTL and testbench
=============================

Name: mux4_rr_tx

Overview:
- Transmit-side counterpart of the 1:4 demux: merges four input channels onto one output lane.
- Each output word is tagged with the 2-bit channel id in `out_sel`, so a downstream demux can route it back using `sel`.
- Channels are picked by a round-robin arbiter with valid/ready handshakes.
- The output lane is a single registered stage that runs at full throughput (one word per clock).

Parameters:
- WIDTH, 8: data width of each channel and of the output lane.
- CNT_W, 16: width of the transferred-word counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  4*WIDTH  channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  4  per-channel valid.
- in_ready  output  4  per-channel ready; combinational; one-hot or zero.
- out_data  output  WIDTH  registered output word.
- out_sel  output  2  registered channel id of out_data; drives the downstream demux `sel`.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.
- xfer_cnt  output  CNT_W  count of words accepted from the inputs.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high, named clk/rst.
  - While rst=1 at a clk edge: out_valid=0, out_data=0, out_sel=0, xfer_cnt=0, rr_ptr=0.
  - in_ready=0 combinationally while rst=1.
- State:
  - rr_ptr[1:0]: highest-priority channel.
  - Output register {out_valid, out_sel, out_data}.
- Load enable:
  - load = !out_valid || out_ready.
- Grant (combinational):
  - If load=1, grant goes to the first channel k with in_valid[k]=1, searching rr_ptr, rr_ptr+1, rr_ptr+2, rr_ptr+3, modulo 4.
  - in_ready[k]=1 only for the granted channel. All other bits are 0.
  - If load=0 or no in_valid is set, in_ready=0000.
- Handshakes:
  - An input transfer happens when in_valid[k] && in_ready[k].
  - An output transfer happens when out_valid && out_ready.
- Register update at each clk edge (rst=0):
  - Grant g this cycle:
    - out_data <= in_data[g].
    - out_sel <= g.
    - out_valid <= 1.
    - rr_ptr <= g+1 (mod 4).
    - xfer_cnt <= xfer_cnt+1.
  - No grant and out_valid && out_ready: out_valid <= 0. out_data and out_sel hold their last values.
  - Otherwise, all registers hold.
- Timing:
  - Latency: an input accepted at edge N appears on the output after edge N.
  - Throughput: with out_ready held at 1, one word per cycle.
- Stall and ordering:
  - While out_valid=1 and out_ready=0, the output register is frozen and in_ready=0000.
  - A sender may drop in_valid only after its transfer completes.
  - rr_ptr advances only on a grant. It does not move during idle or stall.
- Boundary conditions:
  - rr_ptr wraps 3 -> 0.
  - xfer_cnt wraps from all-ones to 0 and never saturates.
  - Simultaneous output drain and new grant in one cycle: the new word replaces the old one with no bubble.
  - All four channels valid: grants rotate 0,1,2,3,0,… starting from rr_ptr.
  - A single valid channel is granted every cycle while load=1.
  - Reset asserted mid-stream: the pending output word is discarded and in_ready=0000 in that cycle. After reset, arbitration restarts at channel 0.
- Fairness: with all channels continuously valid and out_ready=1, every channel is granted exactly once per 4 cycles.

Test Plan:
- Reset, then single channel:
  - Stimulus: release rst; in_valid=0100, in_data[2]=8'hA5, out_ready=1.
  - Response: in_ready=0100 in that cycle. Next cycle out_valid=1, out_sel=2, out_data=8'hA5, xfer_cnt=1.
- All channels valid:
  - Stimulus: in_valid=1111 with data 8'h10,8'h11,8'h12,8'h13 on channels 0..3, out_ready=1, 8 cycles.
  - Response: out_sel sequence 0,1,2,3,0,1,2,3; out_data tracks the selected channel; xfer_cnt=8.
- Backpressure:
  - Stimulus: after a word with out_sel=1 is loaded, hold out_ready=0 for 3 cycles with in_valid=1111.
  - Response: in_ready=0000, out_data and out_sel unchanged. When out_ready returns to 1, the next grant is channel 2 (rr_ptr=2).
- Drain to empty:
  - Stimulus: one word loaded, then in_valid=0000, out_ready=1.
  - Response: out_valid drops to 0 one cycle after the transfer; rr_ptr unchanged.
- Reset mid-stream:
  - Stimulus: with out_valid=1 and out_sel=3, assert rst for 1 cycle.
  - Response: out_valid=0, xfer_cnt=0. The next grant with in_valid=1111 is channel 0.
- Loopback with demux:
  - Stimulus: connect out_data[0] to demux `in` and out_sel to `sel`; drive each channel in turn with bit 1.
  - Response: only demux `out[k]` goes high for channel k.

Source files
------------

// File: rtl/mux4_rr_tx.sv
// mux4_rr_tx: four-channel round-robin merge onto one registered, channel-tagged output lane
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   in_data   : channel data, channel k at [k*WIDTH +: WIDTH]
//   in_valid  : per-channel valid
//   in_ready  : per-channel ready, combinational, one-hot or zero
//   out_data  : registered output word
//   out_sel   : registered channel id of out_data (feeds downstream demux sel)
//   out_valid : registered output valid
//   out_ready : downstream ready
//   xfer_cnt  : wrapping count of words accepted from the inputs
module mux4_rr_tx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4*WIDTH-1:0] in_data,
    input  logic [3:0]         in_valid,
    output logic [3:0]         in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [1:0]         out_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   xfer_cnt
);
    logic [1:0]       r_ptr;
    logic [WIDTH-1:0] r_data;
    logic [1:0]       r_sel;
    logic             r_valid;
    logic [CNT_W-1:0] r_cnt;
    logic             w_load;
    logic             w_found;
    logic [1:0]       w_gnt;
    logic [1:0]       w_idx;

    // Register accepts a new word when empty or draining this cycle, so drain and refill overlap
    assign w_load = !r_valid || out_ready;

    always_comb begin
        w_found = 1'b0;
        w_gnt   = 2'd0;
        w_idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            w_idx = r_ptr + 2'(i);
            if (!w_found && in_valid[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = w_idx;
            end
        end
        if (rst || !w_load)
            w_found = 1'b0;
        in_ready = w_found ? (4'b0001 << w_gnt) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= '0;
            r_data  <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else if (w_found) begin
            r_data  <= in_data[w_gnt*WIDTH +: WIDTH];
            r_sel   <= w_gnt;
            r_valid <= 1'b1;
            r_ptr   <= w_gnt + 2'd1;
            r_cnt   <= r_cnt + 1'b1;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_data  = r_data;
    assign out_sel   = r_sel;
    assign out_valid = r_valid;
    assign xfer_cnt  = r_cnt;
endmodule

// File: tb/tb_mux4_rr_tx.sv
// tb_mux4_rr_tx: directed-vector self-checking bench for mux4_rr_tx
module tb_mux4_rr_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic [3:0]  in_valid = '0;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] xfer_cnt;
    int          n_vec = 0;
    int          n_err = 0;

    mux4_rr_tx #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready),
        .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rdy(input string tag, input logic [3:0] exp);
        #1;
        chk(tag, 32'(in_ready), 32'(exp));
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] s,
                           input logic [7:0] d, input logic [15:0] c);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".sel"},   32'(out_sel),   32'(s));
        chk({tag, ".data"},  32'(out_data),  32'(d));
        chk({tag, ".cnt"},   32'(xfer_cnt),  32'(c));
    endtask

    initial begin
        logic [3:0] dmx;
        // reset with inputs active: nothing may be granted
        in_valid = 4'b1111;
        in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        out_ready = 1'b1;
        chk_rdy("rst.ready", 4'b0000);
        step;
        step;
        chk_out("rst", 1'b0, 2'd0, 8'h00, 16'd0);

        // single channel 2
        rst      = 1'b0;
        in_valid = 4'b0100;
        in_data  = {8'h13, 8'hA5, 8'h11, 8'h10};
        chk_rdy("single.ready", 4'b0100);
        step;
        chk_out("single", 1'b1, 2'd2, 8'hA5, 16'd1);

        // drain to empty; pointer (now 3) must not move while idle
        in_valid = 4'b0000;
        chk_rdy("drain.ready", 4'b0000);
        step;
        chk("drain.valid0", 32'(out_valid), 32'd0);
        step;
        chk("drain.valid1", 32'(out_valid), 32'd0);
        in_valid = 4'b1111;
        in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        chk_rdy("drain.ptr", 4'b1000);
        step;
        chk_out("wrap3", 1'b1, 2'd3, 8'h13, 16'd2);

        // all channels valid: rotation 0,1,2,3,0,1,2,3
        for (int i = 0; i < 8; i++) begin
            chk_rdy("all.ready", 4'b0001 << (i % 4));
            step;
            chk_out("all", 1'b1, 2'(i % 4), 8'h10 + 8'(i % 4), 16'(3 + i));
        end

        // load sel 0 then sel 1, then backpressure
        step;
        step;
        chk_out("bp.load", 1'b1, 2'd1, 8'h11, 16'd12);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_rdy("bp.ready", 4'b0000);
            step;
            chk_out("bp.hold", 1'b1, 2'd1, 8'h11, 16'd12);
        end
        out_ready = 1'b1;
        chk_rdy("bp.resume", 4'b0100);
        step;
        chk_out("bp.next", 1'b1, 2'd2, 8'h12, 16'd13);
        step;
        chk_out("pre.rst", 1'b1, 2'd3, 8'h13, 16'd14);

        // reset mid-stream
        rst = 1'b1;
        chk_rdy("mrst.ready", 4'b0000);
        step;
        chk_out("mrst", 1'b0, 2'd0, 8'h00, 16'd0);
        rst = 1'b0;
        chk_rdy("mrst.ready0", 4'b0001);
        step;
        chk_out("mrst.first", 1'b1, 2'd0, 8'h10, 16'd1);

        // counter wrap: 65535 more grants take 1 -> 0
        for (int i = 0; i < 65535; i++)
            step;
        chk("cnt.wrap", 32'(xfer_cnt), 32'd0);

        // loopback through a 1:4 demux driven by out_data[0]/out_sel
        for (int k = 0; k < 4; k++) begin
            in_valid = 4'b0001 << k;
            in_data  = 32'h1 << (8 * k);
            step;
            dmx = out_valid ? (4'(out_data[0]) << out_sel) : 4'b0000;
            chk("loop.demux", 32'(dmx), 32'(4'b0001 << k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
